// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map plus loader state and error-code enums
package uart_pkg;

  localparam logic [31:0] RX_STATE_OFF = 32'd0;
  localparam logic [31:0] RX_DATA_OFF  = 32'd4;
  localparam logic [31:0] TX_STATE_OFF = 32'd8;
  localparam logic [31:0] TX_DATA_OFF  = 32'd12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POLL   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_UNPACK = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5,
    ST_FAIL   = 3'd6
  } loader_state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_LINE     = 3'd1,
    ERR_BUS      = 3'd2,
    ERR_OVERRUN  = 3'd3,
    ERR_LENGTH   = 3'd4,
    ERR_CHECKSUM = 3'd5
  } err_code_e;

endpackage

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - places payload bytes into word lanes, tracks strobes, flags flush
module uart_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  input  logic [31:0] count_i,
  input  logic [31:0] len_i,
  output logic [31:0] word_o,
  output logic [3:0]  strobe_o,
  output logic        flush_o
);

  logic [31:0] word_q, word_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  lane;

  assign lane     = count_i[1:0];
  // Flush once the word is full or the byte about to load is the last payload byte.
  assign flush_o  = (lane == 2'd3) || ((count_i + 32'd1) == len_i);
  assign word_o   = word_q;
  assign strobe_o = strb_q;

  always_comb begin
    word_d = word_q;
    strb_d = strb_q;
    if (clear_i) begin
      word_d = '0;
      strb_d = '0;
    end else if (load_i) begin
      word_d[{lane, 3'b000} +: 8] = byte_i;
      strb_d[lane]                = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      strb_q <= '0;
    end else begin
      word_q <= word_d;
      strb_q <= strb_d;
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - polls a UART, unpacks a length-prefixed image and writes it to memory
// Optional trailing XOR checksum byte enabled by UART_BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader
  import uart_pkg::*;
#(
  parameter logic [31:0] UART_BASE = 32'h0,
  parameter logic [31:0] LOAD_BASE = 32'h0,
  parameter int unsigned MAX_LEN   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ub_ren,
  output logic        ub_wen,
  output logic [31:0] ub_addr,
  output logic [31:0] ub_wdata,
  output logic [3:0]  ub_strobe,
  input  logic [31:0] ub_rdata,
  input  logic        ub_request_stall,
  input  logic        ub_error,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strobe,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code
);

  loader_state_e state_q, state_d;
  err_code_e     fcode_q, fcode_d, errc_q, errc_d;
  logic [23:0]   rx_q, rx_d;
  logic [1:0]    rem_q, rem_d, pos_q, pos_d;
  logic [2:0]    hdr_q, hdr_d;
  logic [31:0]   len_q, len_d, cnt_q, cnt_d, off_q, off_d;
  logic [7:0]    xor_q, xor_d, cur_byte;
  logic          done_q, done_d, err_q, err_d;
  logic          pk_clear, pk_load, pk_flush;
  logic [31:0]   pk_word, len_shift;
  logic [3:0]    pk_strb;

  uart_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (pk_clear),
    .load_i   (pk_load),
    .byte_i   (cur_byte),
    .count_i  (cnt_q),
    .len_i    (len_q),
    .word_o   (pk_word),
    .strobe_o (pk_strb),
    .flush_o  (pk_flush)
  );

  always_comb begin
    case (pos_q)
      2'd0:    cur_byte = rx_q[7:0];
      2'd1:    cur_byte = rx_q[15:8];
      default: cur_byte = rx_q[23:16];
    endcase
  end

  // Length arrives little-endian, so each header byte shifts in from the top.
  assign len_shift = {cur_byte, len_q[31:8]};

  assign ub_wen     = 1'b0;
  assign ub_wdata   = '0;
  assign ub_strobe  = '0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = errc_q;
  assign mem_wen    = (state_q == ST_WRITE);
  assign mem_addr   = mem_wen ? (LOAD_BASE + off_q) : '0;
  assign mem_wdata  = mem_wen ? pk_word : '0;
  assign mem_strobe = mem_wen ? pk_strb : '0;

  always_comb begin
    state_d  = state_q;
    fcode_d  = fcode_q;
    errc_d   = errc_q;
    rx_d     = rx_q;
    rem_d    = rem_q;
    pos_d    = pos_q;
    hdr_d    = hdr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    xor_d    = xor_q;
    done_d   = done_q;
    err_d    = err_q;
    pk_clear = 1'b0;
    pk_load  = 1'b0;
    ub_ren   = 1'b0;
    ub_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          errc_d   = ERR_NONE;
          hdr_d    = '0;
          len_d    = '0;
          cnt_d    = '0;
          off_d    = '0;
          xor_d    = '0;
          rem_d    = '0;
          pk_clear = 1'b1;
          state_d  = ST_POLL;
        end
      end
      ST_POLL: begin
        ub_ren  = 1'b1;
        ub_addr = UART_BASE + RX_STATE_OFF;
        if (ub_error) begin
          fcode_d = ERR_BUS;
          state_d = ST_FAIL;
        end else if (!ub_request_stall) begin
          if (ub_rdata[1]) begin
            fcode_d = ERR_LINE;
            state_d = ST_FAIL;
          end else if (ub_rdata[0]) begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        ub_ren  = 1'b1;
        ub_addr = UART_BASE + RX_DATA_OFF;
        if (ub_error) begin
          fcode_d = ERR_BUS;
          state_d = ST_FAIL;
        end else if (!ub_request_stall) begin
          rx_d  = ub_rdata[23:0];
          rem_d = ub_rdata[25:24];
          pos_d = '0;
          if (ub_rdata[31:24] == 8'd0) begin
            state_d = ST_POLL;
          end else if (ub_rdata[31:24] > 8'd3) begin
            fcode_d = ERR_OVERRUN;
            state_d = ST_FAIL;
          end else begin
            state_d = ST_UNPACK;
          end
        end
      end
      ST_UNPACK: begin
        pos_d   = pos_q + 2'd1;
        rem_d   = rem_q - 2'd1;
        state_d = (rem_q == 2'd1) ? ST_POLL : ST_UNPACK;
        if (hdr_q != 3'd4) begin
          hdr_d = hdr_q + 3'd1;
          len_d = len_shift;
          if (hdr_q == 3'd3 && (len_shift == 32'd0 || len_shift > MAX_LEN)) begin
            fcode_d = ERR_LENGTH;
            state_d = ST_FAIL;
          end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        end else if (cnt_q == len_q) begin
          if (cur_byte == xor_q) begin
            state_d = ST_FINISH;
          end else begin
            fcode_d = ERR_CHECKSUM;
            state_d = ST_FAIL;
          end
`endif
        end else begin
          pk_load = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          xor_d   = xor_q ^ cur_byte;
          if (pk_flush) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          pk_clear = 1'b1;
          off_d    = off_q + 32'd4;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          state_d  = (rem_q != 2'd0) ? ST_UNPACK : ST_POLL;
`else
          // Anything left in the RX word after the final payload byte is dropped.
          if (cnt_q == len_q) state_d = ST_FINISH;
          else                state_d = (rem_q != 2'd0) ? ST_UNPACK : ST_POLL;
`endif
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        err_d   = 1'b1;
        errc_d  = fcode_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcode_q <= ERR_NONE;
      errc_q  <= ERR_NONE;
      rx_q    <= '0;
      rem_q   <= '0;
      pos_q   <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      xor_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcode_q <= fcode_d;
      errc_q  <= errc_d;
      rx_q    <= rx_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      xor_q   <= xor_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - scoreboard bench for uart_boot_loader (UART_BOOT_LOADER_CHECKSUM_EN aware)
module tb_uart_boot_loader;

  localparam logic [31:0] UB = 32'h1000_0000;
  localparam logic [31:0] LB = 32'h2000_0000;
  localparam int unsigned ML = 4096;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ub_ren, ub_wen;
  logic [31:0] ub_addr, ub_wdata;
  logic [3:0]  ub_strobe;
  logic [31:0] ub_rdata = '0;
  logic        ub_request_stall = 1'b0;
  logic        ub_error = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_strobe;
  logic        mem_ready = 1'b1;
  logic        busy, done, err;
  logic [2:0]  err_code;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] rxq[$];
  wr_t         expq[$];
  bit          rd_pend = 0, stalling = 0, line_err = 0, bus_err = 0;
  int          stall_left = 0, hold_left = 0;

  uart_boot_loader #(.UART_BASE(UB), .LOAD_BASE(LB), .MAX_LEN(ML)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ub_ren(ub_ren), .ub_wen(ub_wen), .ub_addr(ub_addr), .ub_wdata(ub_wdata),
    .ub_strobe(ub_strobe), .ub_rdata(ub_rdata), .ub_request_stall(ub_request_stall),
    .ub_error(ub_error), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strobe(mem_strobe), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // UART responder and memory scoreboard, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rxq.size() > 0) void'(rxq.pop_front());
      rd_pend = 0;
    end
    ub_request_stall = 1'b0;
    ub_error         = 1'b0;
    ub_rdata         = '0;
    if (stall_left > 0 && (stalling || (ub_ren && ub_addr == UB + 32'd4))) begin
      stalling         = 1;
      stall_left--;
      if (stall_left == 0) stalling = 0;
      ub_request_stall = 1'b1;
      ub_rdata         = 32'hFFFF_FFFF;
      check("stall_ren", {31'd0, ub_ren}, 32'd1);
      check("stall_addr", ub_addr, UB + 32'd4);
    end else if (ub_ren) begin
      ub_error = bus_err;
      if (ub_addr == UB + 32'd4) begin
        ub_rdata = (rxq.size() > 0) ? rxq[0] : 32'd0;
        rd_pend  = !bus_err;
      end else begin
        ub_rdata = {30'd0, line_err, rxq.size() > 0};
      end
    end
    mem_ready = 1'b1;
    if (mem_wen) begin
      if (hold_left > 0) begin
        mem_ready = 1'b0;
        hold_left--;
      end
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: addr %h data %h none expected", mem_addr, mem_wdata);
      end else begin
        check("wr_addr", mem_addr, expq[0].addr);
        check("wr_data", mem_wdata, expq[0].data);
        check("wr_strb", {28'd0, mem_strobe}, {28'd0, expq[0].strb});
        if (mem_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rxq.delete();
    expq.delete();
    rd_pend = 0; stalling = 0; stall_left = 0; hold_left = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_and_check(string nm, logic e_done, logic e_err, logic [2:0] e_code);
    bit ok = 0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      if (done || err) begin ok = 1; break; end
      @(negedge clk);
    end
    check({nm, "_finished"}, {31'd0, ok}, 32'd1);
    check({nm, "_done"}, {31'd0, done}, {31'd0, e_done});
    check({nm, "_err"}, {31'd0, err}, {31'd0, e_err});
    check({nm, "_code"}, {29'd0, err_code}, {29'd0, e_code});
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_writes_left"}, expq.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_ub", {30'd0, ub_ren, ub_wen}, 32'd0);
    check("rst_mem", {31'd0, mem_wen}, 32'd0);

    // L=5 payload AA..EE; trailing byte in the final RX word is discarded or is the checksum.
    rxq = '{32'h0300_0005, 32'h0100_0000, 32'h03CC_BBAA,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            32'h03EE_EEDD};
`else
            32'h0399_EEDD};
`endif
    expq = '{'{LB, 32'hDDCC_BBAA, 4'hF}, '{LB + 32'd4, 32'h0000_00EE, 4'h1}};
    run_and_check("basic5", 1'b1, 1'b0, 3'd0);

    line_err = 1;
    run_and_check("line_err", 1'b0, 1'b1, 3'd1);
    line_err = 0;

    bus_err = 1;
    run_and_check("bus_err", 1'b0, 1'b1, 3'd2);
    bus_err = 0;

    rxq = '{32'h0400_0000};
    run_and_check("overrun", 1'b0, 1'b1, 3'd3);

    rxq = '{32'h0300_1001, 32'h0100_0000};
    run_and_check("len_max1", 1'b0, 1'b1, 3'd4);

    rxq = '{32'h0300_0000, 32'h0100_0000};
    run_and_check("len_zero", 1'b0, 1'b1, 3'd4);

    // L=6 with a 3-cycle fetch stall, an empty RX word, and a 5-cycle memory back-pressure.
    stall_left = 3;
    hold_left  = 5;
    rxq = '{32'h02FF_0006, 32'h0012_3456, 32'h0212_0000, 32'h0333_2211,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            32'h0366_5544, 32'h0100_0077};
`else
            32'h0366_5544};
`endif
    expq = '{'{LB, 32'h4433_2211, 4'hF}, '{LB + 32'd4, 32'h0000_6655, 4'h3}};
    run_and_check("stall6", 1'b1, 1'b0, 3'd0);
    check("stall_consumed", stall_left, 32'd0);

    // Reset while a write is stuck behind mem_ready.
    hold_left = 1000;
    rxq  = '{32'h0300_0004, 32'h0100_0000, 32'h0303_0201, 32'h0100_0004};
    expq = '{'{LB, 32'h0403_0201, 4'hF}};
    pulse_start();
    begin
      bit seen = 0;
      for (int i = 0; i < 500; i++) begin
        if (mem_wen) begin seen = 1; break; end
        @(negedge clk);
      end
      check("rstw_reached_write", {31'd0, seen}, 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_mem_wen", {31'd0, mem_wen}, 32'd0);
    check("rstw_mem_addr", mem_addr, 32'd0);
    hold_left = 0;
    expq.delete();
    rxq.delete();

    rxq = '{32'h0300_0004, 32'h0100_0000, 32'h030C_0B0A,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            32'h0100_000D, 32'h0100_0000};
`else
            32'h0100_000D};
`endif
    expq = '{'{LB, 32'h0D0C_0B0A, 4'hF}};
    run_and_check("after_rst4", 1'b1, 1'b0, 3'd0);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    rxq  = '{32'h0300_0002, 32'h0100_0000, 32'h0303_0201};
    expq = '{'{LB, 32'h0000_0201, 4'h3}};
    run_and_check("csum_ok", 1'b1, 1'b0, 3'd0);

    rxq  = '{32'h0300_0002, 32'h0100_0000, 32'h0300_0201};
    expq = '{'{LB, 32'h0000_0201, 4'h3}};
    run_and_check("csum_bad", 1'b0, 1'b1, 3'd5);
`endif

    do_reset();
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
